// File: rtl/bcd_counter_pkg.sv
// Shared BCD constants and helpers for the up/down counter slice.
// Compare helpers work on a fixed maximum width so any DIGITS value can reuse them.
package bcd_counter_pkg;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 10;
  localparam int         MAX_W      = BCD_W * MAX_DIGITS;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

  // Higher digits are visited last, so the most significant differing digit decides.
  function automatic logic bcd_gt(input logic [MAX_W-1:0] a,
                                  input logic [MAX_W-1:0] b,
                                  input int               digits);
    logic gt;
    gt = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])
        gt = a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W];
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control, data and status signals of the BCD up/down counter.
// The master side drives the controls; the counter sits on the slave side.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 8
);
  logic                  enable;
  logic                  up_down;
  logic                  mode;
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [4*DIGITS-1:0]   limit;
  logic [4*DIGITS-1:0]   count;
  logic                  terminal;
  logic                  load_error;

  modport master (
    output enable, up_down, mode, load, data, limit,
    input  count, terminal, load_error
  );

  modport slave (
    input  enable, up_down, mode, load, data, limit,
    output count, terminal, load_error
  );
endinterface

// File: rtl/bcd_digit.sv
// Combinational single-digit BCD +/-1 cell; i_cin requests a step in direction i_up.
// o_cout is the carry (up, 9->0) or borrow (down, 0->9) passed to the next digit.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  input  logic             i_up,
  input  logic             i_cin,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_cout
);

  always_comb begin
    o_digit = i_digit;
    o_cout  = 1'b0;
    if (i_cin) begin
      if (i_up) begin
        if (i_digit >= BCD_MAX) begin
          o_digit = '0;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit + 4'd1;
        end
      end else begin
        if (i_digit == '0) begin
          o_digit = BCD_MAX;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with clamped terminal limit, wrap/saturate modes,
// validated parallel load and registered Terminal / Load_error pulses.
module bcd_updown_counter
  import bcd_counter_pkg::*;
#(
  parameter int                  DIGITS      = 8,
  parameter logic [4*DIGITS-1:0] RESET_VALUE = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  bcd_updown_counter_if.slave    bus
);

  localparam int W = BCD_W * DIGITS;

  logic [W-1:0]      r_count;
  logic              r_terminal;
  logic              r_load_error;

  logic [W-1:0]      w_limit;
  logic [W-1:0]      w_step;
  logic [DIGITS:0]   w_chain;
  logic [DIGITS-1:0] w_data_ok;
  logic [MAX_W-1:0]  w_count_ext;
  logic [MAX_W-1:0]  w_limit_ext;
  logic [MAX_W-1:0]  w_data_ext;
  logic              w_count_gt_l;
  logic              w_count_eq_l;
  logic              w_data_gt_l;
  logic              w_at_floor;
  logic [W-1:0]      w_count_next;
  logic              w_terminal_next;
  logic              w_load_error_next;

  // One ripple chain serves both directions; the final borrow doubles as a zero detect.
  assign w_chain[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_limit[gi*BCD_W +: BCD_W] = bcd_valid(bus.limit[gi*BCD_W +: BCD_W])
                                          ? bus.limit[gi*BCD_W +: BCD_W] : BCD_MAX;
      assign w_data_ok[gi] = bcd_valid(bus.data[gi*BCD_W +: BCD_W]);

      bcd_digit u_digit (
        .i_digit (r_count[gi*BCD_W +: BCD_W]),
        .i_up    (bus.up_down),
        .i_cin   (w_chain[gi]),
        .o_digit (w_step[gi*BCD_W +: BCD_W]),
        .o_cout  (w_chain[gi+1])
      );
    end
  endgenerate

  always_comb begin
    w_count_ext        = '0;
    w_limit_ext        = '0;
    w_data_ext         = '0;
    w_count_ext[W-1:0] = r_count;
    w_limit_ext[W-1:0] = w_limit;
    w_data_ext[W-1:0]  = bus.data;
  end

  assign w_count_gt_l = bcd_gt(w_count_ext, w_limit_ext, DIGITS);
  assign w_data_gt_l  = bcd_gt(w_data_ext, w_limit_ext, DIGITS);
  assign w_count_eq_l = (r_count == w_limit);
  assign w_at_floor   = w_chain[DIGITS];

  always_comb begin
    w_count_next      = r_count;
    w_terminal_next   = 1'b0;
    w_load_error_next = 1'b0;
    if (bus.load) begin
      if (!(&w_data_ok) || w_data_gt_l)
        w_load_error_next = 1'b1;
      else
        w_count_next = bus.data;
    end else if (bus.enable) begin
      if (w_count_gt_l) begin
        // Limit was lowered under the count: pull back to L without a pulse.
        w_count_next = w_limit;
      end else if (bus.up_down) begin
        if (w_count_eq_l) begin
          w_terminal_next = 1'b1;
          if (!bus.mode)
            w_count_next = '0;
        end else begin
          w_count_next = w_step;
        end
      end else begin
        if (w_at_floor) begin
          w_terminal_next = 1'b1;
          if (!bus.mode)
            w_count_next = w_limit;
        end else begin
          w_count_next = w_step;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count      <= RESET_VALUE;
      r_terminal   <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_count      <= w_count_next;
      r_terminal   <= w_terminal_next;
      r_load_error <= w_load_error_next;
    end
  end

  assign bus.count      = r_count;
  assign bus.terminal   = r_terminal;
  assign bus.load_error = r_load_error;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: directed corner cases then random traffic,
// checked against an integer-arithmetic reference model.
module tb_bcd_updown_counter;

  localparam int             DIGITS = 8;
  localparam int             W      = 4 * DIGITS;
  localparam logic [W-1:0]   RV     = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_updown_counter #(
    .DIGITS      (DIGITS),
    .RESET_VALUE (RV)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] count;
    logic         terminal;
    logic         load_error;
  } exp_t;

  exp_t  q_exp[$];
  string q_tag[$];
  int    n_vec = 0;
  int    n_err = 0;

  longint       m_cnt = 0;
  logic [W-1:0] cur_lim = '0;

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint n = 0;
    longint p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n += longint'(v[i*4 +: 4]) * p;
      p *= 10;
    end
    return n;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint n);
    logic [W-1:0] v = '0;
    longint       x = n;
    for (int i = 0; i < DIGITS; i++) begin
      v[i*4 +: 4] = 4'(x % 10);
      x /= 10;
    end
    return v;
  endfunction

  function automatic longint eff_limit(input logic [W-1:0] lim);
    longint n = 0;
    longint p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n += ((lim[i*4 +: 4] > 4'd9) ? 64'd9 : longint'(lim[i*4 +: 4])) * p;
      p *= 10;
    end
    return n;
  endfunction

  function automatic bit has_bad_digit(input logic [W-1:0] d);
    bit bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (d[i*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  task automatic apply(input bit r, input bit en, input bit ud, input bit md, input bit ld,
                       input logic [W-1:0] d, input logic [W-1:0] lim, input string tag);
    longint L;
    exp_t   e;
    @(negedge clk);
    rst         = r;
    bus.enable  = en;
    bus.up_down = ud;
    bus.mode    = md;
    bus.load    = ld;
    bus.data    = d;
    bus.limit   = lim;
    L = eff_limit(lim);
    e.terminal   = 1'b0;
    e.load_error = 1'b0;
    if (r) begin
      m_cnt = bcd2int(RV);
    end else if (ld) begin
      if (has_bad_digit(d) || bcd2int(d) > L) e.load_error = 1'b1;
      else m_cnt = bcd2int(d);
    end else if (en) begin
      if (m_cnt > L) begin
        m_cnt = L;
      end else if (ud) begin
        if (m_cnt == L) begin
          e.terminal = 1'b1;
          if (!md) m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        if (m_cnt == 0) begin
          e.terminal = 1'b1;
          if (!md) m_cnt = L;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
    e.count = int2bcd(m_cnt);
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic load(input logic [W-1:0] d, input logic [W-1:0] lim, input string tag);
    cur_lim = lim;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d, lim, tag);
  endtask

  task automatic step(input bit ud, input bit md, input string tag);
    apply(1'b0, 1'b1, ud, md, 1'b0, '0, cur_lim, tag);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per edge.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        t = q_tag.pop_front();
        n_vec++;
        if (bus.count !== e.count || bus.terminal !== e.terminal ||
            bus.load_error !== e.load_error) begin
          n_err++;
          $display("FAIL %s: got count=%h term=%b lerr=%b, expected count=%h term=%b lerr=%b",
                   t, bus.count, bus.terminal, bus.load_error,
                   e.count, e.terminal, e.load_error);
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_limit();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = int2bcd(longint'($urandom_range(0, 99)));
      1:       v = int2bcd(longint'($urandom_range(0, 99999999)));
      2:       v = 32'h99999999;
      default: begin
        v = '0;
        v[11:0] = 12'($urandom);
      end
    endcase
    return v;
  endfunction

  initial begin
    logic [W-1:0] d;
    bit           r;
    bit           ld;
    bus.enable  = 1'b0;
    bus.up_down = 1'b0;
    bus.mode    = 1'b0;
    bus.load    = 1'b0;
    bus.data    = '0;
    bus.limit   = '0;

    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "reset0");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "reset1");

    load(32'h00000999, 32'h99999999, "load999");
    step(1'b1, 1'b0, "up_carry_1000");

    load(32'h00000059, 32'h00000059, "load59");
    step(1'b1, 1'b0, "wrap_up_to_0");
    load(32'h00000059, 32'h00000059, "load59b");
    step(1'b1, 1'b1, "sat_up_hold");
    step(1'b1, 1'b1, "sat_up_hold2");

    load(32'h00000000, 32'h00000059, "load0");
    step(1'b0, 1'b0, "wrap_down_to_L");
    load(32'h00000000, 32'h00000059, "load0b");
    step(1'b0, 1'b1, "sat_down_hold");
    load(32'h00001000, 32'h99999999, "load1000");
    step(1'b0, 1'b0, "borrow_0999");

    load(32'h0000A000, 32'h99999999, "load_bad_digit");
    load(32'h00000060, 32'h00000059, "load_over_limit");
    cur_lim = 32'h00000059;
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000030, cur_lim, "load_beats_enable");
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, cur_lim, "idle_hold");

    load(32'h00000080, 32'h99999999, "load80");
    cur_lim = 32'h00000059;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, cur_lim, "limit_drop_idle");
    step(1'b1, 1'b0, "out_of_range_up");
    step(1'b1, 1'b0, "from_L_wrap");
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000042, cur_lim, "reset_beats_load");

    cur_lim = 32'h000000A5;
    step(1'b0, 1'b0, "clamped_limit_wrap");
    load(32'h00000095, 32'h000000A5, "load_clamped_L");
    step(1'b1, 1'b0, "clamped_L_wrap_up");

    cur_lim = '0;
    step(1'b1, 1'b0, "L0_up_wrap");
    step(1'b1, 1'b1, "L0_up_sat");
    step(1'b0, 1'b0, "L0_down_wrap");
    step(1'b0, 1'b1, "L0_down_sat");

    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) cur_lim = rand_limit();
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 9) < 7)
        d = int2bcd(longint'($urandom_range(0, 32'(eff_limit(cur_lim)))));
      else
        d = $urandom;
      apply(r, ($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), ld, d, cur_lim, "random");
    end

    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, cur_lim, "final_idle");
    repeat (3) @(negedge clk);
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations pending, expected 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
